// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM port arbiter: the request bundle driven to the sdram core,
// the port owner, the DMA FSM states and one packed upload word.
package sdram_pkg;

    typedef struct packed {
        logic        cs;
        logic        we;
        logic [21:0] addr;
        logic [15:0] din;
        logic [1:0]  ds;
        logic        refresh;
    } ram_req_t;

    typedef enum logic {OWN_ST, OWN_DMA} owner_t;

    typedef enum logic [1:0] {IDLE, DMA_ACC, DMA_GAP} dma_state_t;

    typedef struct packed {
        logic [21:0] addr;
        logic [15:0] data;
        logic [1:0]  ds;
    } dma_word_t;

    // Counter/pointer width that stays legal for a depth or count of 1.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_dma_fifo.sv
// Small queue of packed upload words waiting for a chipset-declared free slot.
// A push while full is dropped unless a pop happens in the same clock.
module sdram_dma_fifo
    import sdram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  dma_word_t                   wdata,
    input  logic                        pop,
    output dma_word_t                   rdata,
    output logic                        full,
    output logic                        empty,
    output logic [clog2_min1(DEPTH):0]  count
);
    localparam int AW = clog2_min1(DEPTH);

    dma_word_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sdram_dma_arbiter.sv
// Shares the SDRAM word port between the ST chipset (default owner, zero-latency pass-through)
// and a byte-wide MCU upload port whose packed words are written only in chipset free slots.
module sdram_dma_arbiter
    import sdram_pkg::*;
#(
    parameter int ACCESS_CYCLES = 4,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ram_ready,
    input  logic        st_cs,
    input  logic        st_we,
    input  logic [21:0] st_addr,
    input  logic [15:0] st_din,
    input  logic [1:0]  st_ds,
    input  logic        st_refresh,
    output logic [15:0] st_dout,
    input  logic        dma_window,
    input  logic        dma_start,
    input  logic [21:0] dma_addr,
    input  logic        dma_strobe,
    input  logic [7:0]  dma_data,
    input  logic        dma_flush,
    output logic        dma_busy,
    output logic        dma_overrun,
    output logic        dma_collision,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [21:0] ram_addr,
    output logic [15:0] ram_din,
    output logic [1:0]  ram_ds,
    output logic        ram_refresh,
    input  logic [15:0] ram_dout
);
    localparam int CW = clog2_min1(ACCESS_CYCLES);
    localparam int FW = clog2_min1(FIFO_DEPTH);

    dma_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    owner_t        owner;
    ram_req_t      st_req, dma_req, ram_req;

    logic          have, have_n;
    logic [7:0]    upper, upper_n;
    logic [21:0]   waddr, waddr_n;
    logic          start_pend, start_req, start_ok;
    logic          push, push_ok, pop, fifo_left;
    dma_word_t     wword, head;
    logic          fifo_full, fifo_empty;
    logic [FW:0]   fifo_count;

    sdram_dma_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wword),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        unique case (state)
            IDLE:
                if (ram_ready && dma_window && !st_cs && !st_refresh && !fifo_empty) begin
                    state_n = DMA_ACC;
                    cnt_n   = '0;
                end
            DMA_ACC:
                if (cnt == CW'(ACCESS_CYCLES - 1)) state_n = DMA_GAP;
                else                               cnt_n   = cnt + CW'(1);
            DMA_GAP: begin
                // cs low for one clock so the sdram core sees a fresh request edge
                pop     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A start outside IDLE waits; bytes and flushes arriving while it waits are discarded.
    assign start_req = dma_start || start_pend;
    assign start_ok  = start_req && (state == IDLE);

    always_comb begin
        push    = 1'b0;
        wword   = '{addr: waddr, data: {upper, dma_data}, ds: 2'b00};
        have_n  = have;
        upper_n = upper;
        waddr_n = waddr;
        if (start_ok) begin
            have_n  = 1'b0;
            waddr_n = dma_addr;
        end else if (!start_req) begin
            if (dma_strobe) begin
                if (have) begin
                    push    = 1'b1;
                    have_n  = 1'b0;
                    waddr_n = waddr + 22'd1;
                end else begin
                    upper_n = dma_data;
                    have_n  = 1'b1;
                end
            end else if (dma_flush && have) begin
                push       = 1'b1;
                wword.data = {upper, 8'h00};
                wword.ds   = 2'b01;
                have_n     = 1'b0;
            end
        end
    end

    assign push_ok   = push && (!fifo_full || pop);
    assign fifo_left = push_ok || (fifo_count != {{FW{1'b0}}, pop});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            have          <= 1'b0;
            upper         <= '0;
            waddr         <= '0;
            start_pend    <= 1'b0;
            dma_overrun   <= 1'b0;
            dma_collision <= 1'b0;
            dma_busy      <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            have          <= have_n;
            upper         <= upper_n;
            waddr         <= waddr_n;
            start_pend    <= start_req && !start_ok;
            dma_overrun   <= start_ok ? 1'b0 : (dma_overrun || (push && !push_ok));
            dma_collision <= start_ok ? 1'b0
                           : (dma_collision || ((st_cs || st_refresh) && state != IDLE));
            dma_busy      <= have_n || fifo_left || (state_n != IDLE);
        end
    end

    assign owner   = (state == IDLE) ? OWN_ST : OWN_DMA;
    assign st_req  = '{cs: st_cs, we: st_we, addr: st_addr, din: st_din, ds: st_ds, refresh: st_refresh};
    assign dma_req = '{cs: (state == DMA_ACC), we: (state == DMA_ACC), addr: head.addr,
                       din: head.data, ds: head.ds, refresh: 1'b0};
    assign ram_req = (owner == OWN_DMA) ? dma_req : st_req;

    assign ram_cs      = ram_req.cs;
    assign ram_we      = ram_req.we;
    assign ram_addr    = ram_req.addr;
    assign ram_din     = ram_req.din;
    assign ram_ds      = ram_req.ds;
    assign ram_refresh = ram_req.refresh;
    assign st_dout     = ram_dout;

endmodule
